// File: rtl/uncache_axi_bridge.sv
// Uncached load/store to single-beat AXI4 bridge; one transaction in flight, strongly ordered.
// Build option: define UNCACHE_WRITE_BUFFER_EN to post writes (wr_valid on acceptance, drain in background).
module uncache_axi_bridge #(
  parameter int unsigned         ID_WIDTH = 4,
  parameter logic [ID_WIDTH-1:0] RD_ID    = ID_WIDTH'(1),
  parameter logic [ID_WIDTH-1:0] WR_ID    = ID_WIDTH'(1)
) (
  input  logic                clk,
  input  logic                resetn,
  // uncached read request
  input  logic                rd_req,
  input  logic [31:0]         rd_addr,
  input  logic [1:0]          load_type,
  output logic                rd_rdy,
  output logic                ret_valid,
  output logic [31:0]         ret_data,
  // uncached write request
  input  logic                wr_req,
  input  logic [31:0]         wr_addr,
  input  logic [31:0]         wr_data,
  input  logic [3:0]          wr_wstrb,
  output logic                wr_rdy,
  output logic                wr_valid,
  // AXI read address
  output logic [ID_WIDTH-1:0] arid,
  output logic [31:0]         araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  // AXI read data
  input  logic [31:0]         rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  // AXI write address
  output logic [ID_WIDTH-1:0] awid,
  output logic [31:0]         awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  // AXI write data
  output logic [31:0]         wdata,
  output logic [3:0]          wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  // AXI write response
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_AR   = 3'd1,
    RD_R    = 3'd2,
    WR_AW_W = 3'd3,
    WR_B    = 3'd4
  } state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;

  state_e      state_q, state_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        ret_valid_q, ret_valid_d;
  logic        wr_valid_q, wr_valid_d;
  logic [31:0] ret_data_q, ret_data_d;

  // Request payload; only meaningful while its transaction is in flight, so no reset.
  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  logic        rd_accept, wr_accept;
  logic [2:0]  rd_size;

  // Response status and rlast carry no information for single-beat, error-agnostic accesses.
  logic        unused_resp;
  assign unused_resp = ^{rresp, rlast, bresp};

  assign rd_size = (load_type == 2'd3) ? 3'd2 : {1'b0, load_type};

  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    ret_valid_d = 1'b0;
    wr_valid_d  = 1'b0;
    ret_data_d  = ret_data_q;
    rd_accept   = 1'b0;
    wr_accept   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr_req) begin
          wr_accept = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_AW_W;
`ifdef UNCACHE_WRITE_BUFFER_EN
          wr_valid_d = 1'b1;
`endif
        end else if (rd_req) begin
          rd_accept = 1'b1;
          state_d   = RD_AR;
        end
      end
      RD_AR: begin
        if (arready) state_d = RD_R;
      end
      RD_R: begin
        if (rvalid) begin
          ret_data_d  = rdata;
          ret_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      WR_AW_W: begin
        // AW and W retire independently; either may land first or both together.
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (aw_done_d && w_done_d) state_d = WR_B;
      end
      WR_B: begin
        if (bvalid) begin
`ifndef UNCACHE_WRITE_BUFFER_EN
          wr_valid_d = 1'b1;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      ret_valid_q <= 1'b0;
      wr_valid_q  <= 1'b0;
      ret_data_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      ret_valid_q <= ret_valid_d;
      wr_valid_q  <= wr_valid_d;
      ret_data_q  <= ret_data_d;
    end
  end

  // Read and write share the address register since only one transaction is ever in flight.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      addr_q  <= wr_addr;
      wdata_q <= wr_data;
      wstrb_q <= wr_wstrb;
    end else if (rd_accept) begin
      addr_q <= rd_addr;
      size_q <= rd_size;
    end
  end

  // Valids derive from registered state only, never from ready.
  assign rd_rdy    = (state_q == IDLE);
  assign wr_rdy    = (state_q == IDLE);
  assign ret_valid = ret_valid_q;
  assign ret_data  = ret_data_q;
  assign wr_valid  = wr_valid_q;

  assign arid    = RD_ID;
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = size_q;
  assign arburst = BURST_INCR;
  assign arvalid = (state_q == RD_AR);
  assign rready  = (state_q == RD_R);

  assign awid    = WR_ID;
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = 3'd2;
  assign awburst = BURST_INCR;
  assign awvalid = (state_q == WR_AW_W) && !aw_done_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = (state_q == WR_AW_W) && !w_done_q;
  assign bready  = (state_q == WR_B);

endmodule

// File: tb/tb_uncache_axi_bridge.sv
// Directed bench for uncache_axi_bridge; inputs change and outputs are checked on the falling edge.
module tb_uncache_axi_bridge;

`ifdef UNCACHE_WRITE_BUFFER_EN
  localparam logic WB = 1'b1;
`else
  localparam logic WB = 1'b0;
`endif

  logic        clk, resetn;
  logic        rd_req, rd_rdy, ret_valid;
  logic [31:0] rd_addr, ret_data;
  logic [1:0]  load_type;
  logic        wr_req, wr_rdy, wr_valid;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_wstrb;
  logic [3:0]  arid, awid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  int vectors = 0;
  int miscompares = 0;

  uncache_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_addr(rd_addr), .load_type(load_type), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_data(ret_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_wstrb(wr_wstrb),
    .wr_rdy(wr_rdy), .wr_valid(wr_valid),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0; rd_req = 1'b0; rd_addr = '0; load_type = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0; wr_wstrb = '0;
    arready = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = '0; bvalid = 1'b0;

    // reset state
    step; step;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_bready", bready, 0);
    chk("rst_ret_valid", ret_valid, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_ret_data", ret_data, 0);
    resetn = 1'b1;
    step;
    chk("post_rst_rd_rdy", rd_rdy, 1);
    chk("post_rst_wr_rdy", wr_rdy, 1);

    // word read, rvalid arrives a few cycles into RD_R
    rd_req = 1'b1; rd_addr = 32'hBFAF_8000; load_type = 2'd2; arready = 1'b1;
    step;
    rd_req = 1'b0; rd_addr = 32'h0; load_type = 2'd0;
    chk("rd_arvalid", arvalid, 1);
    chk("rd_araddr", araddr, 32'hBFAF_8000);
    chk("rd_arsize", arsize, 2);
    chk("rd_arlen", arlen, 0);
    chk("rd_arburst", arburst, 1);
    chk("rd_arid", arid, 1);
    chk("rd_rdy_busy_ar", rd_rdy, 0);
    chk("wr_rdy_busy_ar", wr_rdy, 0);
    step;
    arready = 1'b0;
    chk("rd_arvalid_drop", arvalid, 0);
    chk("rd_rready", rready, 1);
    chk("rd_rdy_busy_r", rd_rdy, 0);
    step; step;
    chk("rd_rready_wait", rready, 1);
    chk("rd_no_early_ret", ret_valid, 0);
    rvalid = 1'b1; rdata = 32'h1234_5678;
    step;
    rvalid = 1'b0; rdata = 32'hDEAD_BEEF;
    chk("rd_ret_valid", ret_valid, 1);
    chk("rd_ret_data", ret_data, 32'h1234_5678);
    chk("rd_rready_off", rready, 0);
    chk("rd_rdy_back", rd_rdy, 1);
    step;
    chk("rd_ret_pulse_end", ret_valid, 0);

    // byte write, W accepted in cycle 1, AW in cycle 4
    wr_req = 1'b1; wr_addr = 32'hBFD0_03F8; wr_data = 32'h0000_00A5; wr_wstrb = 4'b0001;
    awready = 1'b0; wready = 1'b1;
    step;
    wr_req = 1'b0; wr_addr = 32'h0; wr_data = 32'hFFFF_FFFF; wr_wstrb = 4'b1111;
    chk("wr_awvalid_c1", awvalid, 1);
    chk("wr_wvalid_c1", wvalid, 1);
    chk("wr_awaddr", awaddr, 32'hBFD0_03F8);
    chk("wr_wdata", wdata, 32'h0000_00A5);
    chk("wr_wstrb", wstrb, 4'b0001);
    chk("wr_awsize", awsize, 2);
    chk("wr_awlen", awlen, 0);
    chk("wr_awburst", awburst, 1);
    chk("wr_wlast", wlast, 1);
    chk("wr_awid", awid, 1);
    chk("wr_rdy_busy", wr_rdy, 0);
    chk("rd_rdy_busy_w", rd_rdy, 0);
    chk("wr_valid_c1", wr_valid, WB);
    step;
    wready = 1'b0;
    chk("wr_wvalid_c2", wvalid, 0);
    chk("wr_awvalid_c2", awvalid, 1);
    chk("wr_bready_c2", bready, 0);
    step;
    chk("wr_awvalid_c3", awvalid, 1);
    chk("wr_awaddr_c3", awaddr, 32'hBFD0_03F8);
    step;
    awready = 1'b1;
    chk("wr_awvalid_c4", awvalid, 1);
    step;
    awready = 1'b0;
    chk("wr_awvalid_c5", awvalid, 0);
    chk("wr_bready", bready, 1);
    chk("wr_valid_before_b", wr_valid, 0);
    bvalid = 1'b1;
    step;
    bvalid = 1'b0;
    chk("wr_valid_after_b", wr_valid, !WB);
    chk("wr_bready_off", bready, 0);
    chk("wr_rdy_back", wr_rdy, 1);
    step;
    chk("wr_valid_end", wr_valid, 0);

    // simultaneous requests: write first, read held until write completes
    wr_req = 1'b1; wr_addr = 32'h1000_0040; wr_data = 32'h0BAD_F00D; wr_wstrb = 4'b1111;
    rd_req = 1'b1; rd_addr = 32'h2000_0082; load_type = 2'd1;
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    step;
    wr_req = 1'b0;
    chk("both_awvalid", awvalid, 1);
    chk("both_arvalid_c1", arvalid, 0);
    chk("both_rd_rdy_c1", rd_rdy, 0);
    step;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
    chk("both_bready", bready, 1);
    chk("both_arvalid_c2", arvalid, 0);
    step;
    bvalid = 1'b0;
    chk("both_wr_valid", wr_valid, !WB);
    chk("both_rd_rdy_c3", rd_rdy, 1);
    chk("both_arvalid_c3", arvalid, 0);
    step;
    rd_req = 1'b0;
    chk("both_arvalid_c4", arvalid, 1);
    chk("both_araddr", araddr, 32'h2000_0082);
    chk("both_arsize_half", arsize, 1);
    step;
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h0000_BEEF;
    step;
    rvalid = 1'b0;
    chk("both_ret_valid", ret_valid, 1);
    chk("both_ret_data", ret_data, 32'h0000_BEEF);

    // AR backpressure for 10 cycles, size code 3 maps to word
    step;
    rd_req = 1'b1; rd_addr = 32'h1FC0_0010; load_type = 2'd3; arready = 1'b0;
    step;
    rd_req = 1'b0; rd_addr = 32'h0; load_type = 2'd0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_arvalid", arvalid, 1);
      chk("bp_araddr", araddr, 32'h1FC0_0010);
      chk("bp_arsize", arsize, 2);
      chk("bp_ret_valid", ret_valid, 0);
      step;
    end
    arready = 1'b1;
    step;
    arready = 1'b0;
    chk("bp_rready", rready, 1);
    rvalid = 1'b1; rdata = 32'hCAFE_F00D;
    step;
    rvalid = 1'b0;
    chk("bp_ret_valid_end", ret_valid, 1);
    chk("bp_ret_data", ret_data, 32'hCAFE_F00D);

    // asynchronous reset while waiting in RD_R
    step;
    rd_req = 1'b1; rd_addr = 32'hBFAF_0004; load_type = 2'd2; arready = 1'b1;
    step;
    rd_req = 1'b0;
    step;
    arready = 1'b0;
    chk("arst_rready_before", rready, 1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_rready", rready, 0);
    chk("arst_rd_rdy", rd_rdy, 1);
    chk("arst_arvalid", arvalid, 0);
    chk("arst_ret_data", ret_data, 0);
    chk("arst_ret_valid", ret_valid, 0);
    step;
    resetn = 1'b1;
    step;
    chk("arst_idle_rready", rready, 0);
    rd_req = 1'b1; rd_addr = 32'hBFD0_0003; load_type = 2'd0; arready = 1'b1;
    step;
    rd_req = 1'b0;
    chk("arst_arvalid_new", arvalid, 1);
    chk("arst_araddr_new", araddr, 32'hBFD0_0003);
    chk("arst_arsize_byte", arsize, 0);
    step;
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h5A5A_0003;
    step;
    rvalid = 1'b0;
    chk("arst_ret_valid_new", ret_valid, 1);
    chk("arst_ret_data_new", ret_data, 32'h5A5A_0003);

`ifdef UNCACHE_WRITE_BUFFER_EN
    // posted write followed at once by a read: read waits for the B handshake
    step;
    wr_req = 1'b1; wr_addr = 32'hBFD0_0100; wr_data = 32'h7777_0001; wr_wstrb = 4'b0011;
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    step;
    wr_req = 1'b0;
    rd_req = 1'b1; rd_addr = 32'hBFD0_0104; load_type = 2'd2;
    chk("wb_wr_valid_early", wr_valid, 1);
    chk("wb_rd_rdy_c1", rd_rdy, 0);
    chk("wb_wr_rdy_c1", wr_rdy, 0);
    step;
    awready = 1'b0; wready = 1'b0;
    chk("wb_wr_valid_c2", wr_valid, 0);
    chk("wb_rd_rdy_c2", rd_rdy, 0);
    chk("wb_arvalid_c2", arvalid, 0);
    step;
    chk("wb_rd_rdy_c3", rd_rdy, 0);
    bvalid = 1'b1;
    step;
    bvalid = 1'b0;
    chk("wb_rd_rdy_after_b", rd_rdy, 1);
    chk("wb_no_second_wr_valid", wr_valid, 0);
    chk("wb_arvalid_c4", arvalid, 0);
    step;
    rd_req = 1'b0;
    chk("wb_arvalid_c5", arvalid, 1);
    chk("wb_araddr", araddr, 32'hBFD0_0104);
    step;
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h0104_0104;
    step;
    rvalid = 1'b0;
    chk("wb_ret_data", ret_data, 32'h0104_0104);
`endif

    step;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
